// File: rtl/pipeline_stall_controller_pkg.sv
// Shared types and constants for the pipeline freeze/flush sequencer.
package pipeline_stall_controller_pkg;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        MULTI = 1'b1
    } state_e;

    localparam int MULTI_LAT_MIN = 3;
    localparam int STALL_CNT_W   = 32;

endpackage

// File: rtl/pipeline_stall_controller_stall_cycle_counter.sv
// Saturating count of cycles in which any pipeline register is frozen.
module stall_cycle_counter
    import pipeline_stall_controller_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   inc_i,
    output logic [STALL_CNT_W-1:0] count_o
);

    logic [STALL_CNT_W-1:0] count_q;
    logic [STALL_CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc_i && (count_q != {STALL_CNT_W{1'b1}})) begin
            count_d = count_q + STALL_CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Freeze/flush sequencer for the 5-stage pipeline: memory stall, multi-cycle EXE,
// ID hazard and taken branch. Define STALL_COUNTER_EN to add the Stall_Cycles output.
//
// state | meaning
// RUN   | normal flow; hazard freeze, branch flush or multi-cycle start
// MULTI | multi-cycle op resident in EXE; front end frozen until cnt reaches 1
module pipeline_stall_controller
    import pipeline_stall_controller_pkg::*;
#(
    parameter int MULTI_LAT = 4,
    parameter int CNT_W     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic Hazard_Detected,
    input  logic Branch_Taken,
    input  logic Mem_Req,
    input  logic Mem_Ready,
    input  logic Exe_Multi_Start,
    output logic Freeze_IF,
    output logic Freeze_ID,
    output logic Freeze_EXE,
    output logic Freeze_MEM,
    output logic Flush_ID,
    output logic Flush_EXE,
    output logic Bubble_MEM,
    output logic Multi_Busy
`ifdef STALL_COUNTER_EN
    ,
    output logic [STALL_CNT_W-1:0] Stall_Cycles
`endif
);

    // Out-of-range latencies are clamped to the shortest supported op.
    localparam int               LAT_EFF  = (MULTI_LAT < MULTI_LAT_MIN) ? MULTI_LAT_MIN : MULTI_LAT;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LAT_EFF - 2);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_stall;

    logic frz_if_d, frz_id_d, frz_exe_d, frz_mem_d;
    logic fl_id_d, fl_exe_d, bub_mem_d;

    assign mem_stall = Mem_Req & ~Mem_Ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        frz_if_d  = 1'b0;
        frz_id_d  = 1'b0;
        frz_exe_d = 1'b0;
        frz_mem_d = 1'b0;
        fl_id_d   = 1'b0;
        fl_exe_d  = 1'b0;
        bub_mem_d = 1'b0;
        if (mem_stall) begin
            frz_if_d  = 1'b1;
            frz_id_d  = 1'b1;
            frz_exe_d = 1'b1;
            frz_mem_d = 1'b1;
        end else begin
            case (state_q)
                RUN: begin
                    if (Exe_Multi_Start) begin
                        frz_if_d  = 1'b1;
                        frz_id_d  = 1'b1;
                        frz_exe_d = 1'b1;
                        bub_mem_d = 1'b1;
                        cnt_d     = CNT_LOAD;
                        state_d   = MULTI;
                    end else if (Hazard_Detected) begin
                        frz_if_d  = 1'b1;
                        frz_id_d  = 1'b1;
                        fl_exe_d  = 1'b1;
                    end else if (Branch_Taken) begin
                        fl_id_d   = 1'b1;
                    end
                end
                MULTI: begin
                    frz_if_d  = 1'b1;
                    frz_id_d  = 1'b1;
                    frz_exe_d = 1'b1;
                    bub_mem_d = 1'b1;
                    cnt_d     = cnt_q - CNT_ONE;
                    if (cnt_q == CNT_ONE) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Reset is asynchronous, so outputs are gated directly rather than waiting for a clock.
    assign Freeze_IF  = rst & frz_if_d;
    assign Freeze_ID  = rst & frz_id_d;
    assign Freeze_EXE = rst & frz_exe_d;
    assign Freeze_MEM = rst & frz_mem_d;
    assign Flush_ID   = rst & fl_id_d;
    assign Flush_EXE  = rst & fl_exe_d;
    assign Bubble_MEM = rst & bub_mem_d;
    assign Multi_Busy = rst & (state_q == MULTI);

`ifdef STALL_COUNTER_EN
    logic freeze_any;
    assign freeze_any = Freeze_IF | Freeze_ID | Freeze_EXE | Freeze_MEM;

    stall_cycle_counter u_stall_cycle_counter (
        .clk     (clk),
        .rst     (rst),
        .inc_i   (freeze_any),
        .count_o (Stall_Cycles)
    );
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Scoreboard bench for pipeline_stall_controller (MULTI_LAT=4).
module tb_pipeline_stall_controller;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hz = 1'b0, br = 1'b0, mreq = 1'b0, mrdy = 1'b0, ems = 1'b0;
    logic f_if, f_id, f_exe, f_mem, fl_id, fl_exe, bub_mem, busy;
`ifdef STALL_COUNTER_EN
    logic [31:0] stall_cycles;
`endif

    always #5 clk = ~clk;

    pipeline_stall_controller #(.MULTI_LAT(4), .CNT_W(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .Hazard_Detected (hz),
        .Branch_Taken    (br),
        .Mem_Req         (mreq),
        .Mem_Ready       (mrdy),
        .Exe_Multi_Start (ems),
        .Freeze_IF       (f_if),
        .Freeze_ID       (f_id),
        .Freeze_EXE      (f_exe),
        .Freeze_MEM      (f_mem),
        .Flush_ID        (fl_id),
        .Flush_EXE       (fl_exe),
        .Bubble_MEM      (bub_mem),
        .Multi_Busy      (busy)
`ifdef STALL_COUNTER_EN
        ,
        .Stall_Cycles    (stall_cycles)
`endif
    );

    typedef struct {
        logic [7:0] v;
        string      n;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;
    int exp_stall_accum = 0;
    int exp_stall_settled = 0;

    // Vector order: Freeze_IF Freeze_ID Freeze_EXE Freeze_MEM Flush_ID Flush_EXE Bubble_MEM Multi_Busy
    localparam logic [7:0] IDLE  = 8'b0000_0000;
    localparam logic [7:0] HAZ   = 8'b1100_0100;
    localparam logic [7:0] BRN   = 8'b0000_1000;
    localparam logic [7:0] MSTRT = 8'b1110_0010;
    localparam logic [7:0] MBUSY = 8'b1110_0011;
    localparam logic [7:0] MEMST = 8'b1111_0000;
    localparam logic [7:0] MEMMB = 8'b1111_0001;

    task automatic step(input logic r, input logic h, input logic b, input logic mq,
                        input logic md, input logic e, input logic [7:0] exp_v, input string name);
        exp_t x;
        @(posedge clk);
        #1;
        exp_stall_settled = exp_stall_accum;
        rst = r; hz = h; br = b; mreq = mq; mrdy = md; ems = e;
        if (!r) begin
            exp_stall_accum = 0;
            exp_stall_settled = 0;
        end else if (exp_v[7:4] != 4'b0000) begin
            exp_stall_accum++;
        end
        x.v = exp_v;
        x.n = name;
        q.push_back(x);
    endtask

    task automatic check_stall(input string name);
`ifdef STALL_COUNTER_EN
        #1;
        checks++;
        if (stall_cycles != 32'(exp_stall_settled)) begin
            failures++;
            $display("FAIL %s: Stall_Cycles got %0d expected %0d", name, stall_cycles, exp_stall_settled);
        end
`else
        if (name.len() == 0) $display("unnamed stall check");
`endif
    endtask

    initial begin : monitor
        exp_t x;
        logic [7:0] got;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                got = {f_if, f_id, f_exe, f_mem, fl_id, fl_exe, bub_mem, busy};
                checks++;
                if (got !== x.v) begin
                    failures++;
                    $display("FAIL %s: outputs got %b expected %b", x.n, got, x.v);
                end
            end
        end
    end

    initial begin : driver
        //    rst  hz   br   mreq mrdy ems
        step(0, 1, 1, 1, 0, 1, IDLE,  "reset_forces_zero");
        step(1, 0, 0, 0, 0, 0, IDLE,  "idle_after_reset");
        step(1, 1, 1, 0, 0, 0, HAZ,   "hazard_c1_branch_masked");
        step(1, 1, 1, 0, 0, 0, HAZ,   "hazard_c2_branch_masked");
        step(1, 0, 1, 0, 0, 0, BRN,   "branch_flush");
        step(1, 0, 0, 0, 0, 0, IDLE,  "branch_one_cycle_only");
        check_stall("stall_after_hazard");
        step(1, 0, 0, 0, 0, 1, MSTRT, "multi_start");
        step(1, 1, 1, 0, 0, 0, MBUSY, "multi_cnt2_ignores_hz_br");
        step(1, 1, 0, 0, 0, 0, MBUSY, "multi_cnt1_last_frozen");
        step(1, 0, 0, 0, 0, 0, IDLE,  "multi_back_to_run");
        check_stall("stall_after_multi");
        step(1, 0, 0, 0, 0, 1, MSTRT, "mem_multi_start");
        step(1, 0, 0, 0, 0, 0, MBUSY, "mem_multi_cnt2");
        step(1, 0, 0, 1, 0, 0, MEMMB, "mem_stall_in_multi_1");
        step(1, 1, 0, 1, 0, 0, MEMMB, "mem_stall_in_multi_2");
        step(1, 0, 0, 1, 0, 0, MEMMB, "mem_stall_in_multi_3");
        step(1, 0, 0, 1, 1, 0, MBUSY, "mem_ready_cnt1_held");
        step(1, 0, 0, 0, 0, 0, IDLE,  "mem_multi_run");
        check_stall("stall_after_mem_multi");
        step(1, 1, 0, 1, 0, 0, MEMST, "mem_stall_masks_hazard");
        step(1, 0, 0, 1, 0, 1, MEMST, "mem_stall_masks_start");
        step(1, 0, 0, 0, 0, 1, MSTRT, "start_after_mem_release");
        step(1, 0, 0, 0, 0, 0, MBUSY, "rst_test_multi_cycle1");
        step(0, 1, 1, 1, 0, 1, IDLE,  "reset_in_multi_zero");
        check_stall("stall_cleared_by_reset");
        step(1, 0, 0, 0, 0, 0, IDLE,  "run_after_reset_abort");
        step(1, 1, 0, 0, 0, 0, HAZ,   "hazard_after_abort");
        step(1, 0, 0, 0, 0, 1, MSTRT, "held_start_op1");
        step(1, 0, 0, 0, 0, 1, MBUSY, "held_start_cnt2");
        step(1, 0, 0, 0, 0, 1, MBUSY, "held_start_cnt1");
        step(1, 0, 0, 0, 0, 1, MSTRT, "held_start_new_op");
        step(1, 0, 0, 0, 0, 0, MBUSY, "new_op_cnt2");
        step(1, 0, 1, 0, 0, 0, MBUSY, "new_op_cnt1");
        step(1, 0, 1, 0, 0, 0, BRN,   "branch_after_new_op");
        step(1, 0, 0, 0, 0, 0, IDLE,  "final_idle");
        check_stall("stall_final");
        for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: pending got %0d expected 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
